// File: rtl/spi_flash_pkg.sv
// Shared opcodes and FSM state type for the SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_JEDEC = 8'h9F;
    localparam logic [7:0] CMD_RDSR  = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_flash_responder_sync.sv
// Two-flop synchroniser for the SPI pins plus SCK edge detection.
// Bus order is {mosi, sck, cs_n}. Every flop resets to 0, so a CS that is
// already low when reset releases never looks like a fresh CS falling edge.
module spi_pin_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] pins_in,
    output logic       cs_n_s,
    output logic       mosi_s,
    output logic       sck_rise,
    output logic       sck_fall
);

    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic       sck_dly_q, sck_dly_d;

    // Next values of the synchroniser chain and the SCK history flop.
    always_comb begin
        sync1_d   = pins_in;
        sync2_d   = sync1_q;
        sck_dly_d = sync2_q[1];
    end

    // Register the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 3'b000;
            sync2_q   <= 3'b000;
            sck_dly_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sck_dly_q <= sck_dly_d;
        end
    end

    assign cs_n_s   = sync2_q[0];
    assign mosi_s   = sync2_q[2];
    assign sck_rise =  sync2_q[1] & ~sck_dly_q;
    assign sck_fall = ~sync2_q[1] &  sck_dly_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-NOR read responder backed by a byte-wide memory.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | CS high, or CS low but not yet seen high since reset/end
// ST_CMD    | shifting in the command byte
// ST_ADDR   | shifting in the 3 address bytes (READ only)
// ST_DATA   | shifting out response bytes, MISO driven
// ST_IGNORE | unknown command, waiting for CS high
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W   = 17,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata
);

    logic cs_n_s, mosi_s, sck_rise, sck_fall;

    spi_pin_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .pins_in  ({spi_mosi, spi_sck, spi_cs_n}),
        .cs_n_s   (cs_n_s),
        .mosi_s   (mosi_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall)
    );

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [6:0]        rx_sr_q, rx_sr_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [ADDR_W-2:0] addr_sr_q, addr_sr_d;
    logic [7:0]        tx_sr_q, tx_sr_d;
    logic [7:0]        prefetch_q, prefetch_d;
    logic              load_pend_q, load_pend_d;
    logic              armed_q, armed_d;
    logic              ren_dly_q, ren_dly_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic              mem_ren_q, mem_ren_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] addr_full;
    logic [7:0]        next_byte;

    // The byte completed by the current SCK rise, and the address it ends.
    assign rx_byte   = {rx_sr_q, mosi_s};
    assign addr_full = {addr_sr_q, mosi_s};

    // Byte to load into the TX register on the next load falling edge.
    always_comb begin
        next_byte = 8'h00;
        if (cmd_q == CMD_READ) begin
            next_byte = prefetch_q;
        end else if (cmd_q == CMD_JEDEC) begin
            case (byte_cnt_q)
                2'd0:    next_byte = JEDEC_ID[23:16];
                2'd1:    next_byte = JEDEC_ID[15:8];
                2'd2:    next_byte = JEDEC_ID[7:0];
                default: next_byte = 8'h00;
            endcase
        end
    end

    // FSM, counters, shift registers and memory port next-state logic.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        rx_sr_d     = rx_sr_q;
        cmd_d       = cmd_q;
        addr_sr_d   = addr_sr_q;
        tx_sr_d     = tx_sr_q;
        prefetch_d  = prefetch_q;
        load_pend_d = load_pend_q;
        armed_d     = armed_q;
        ren_dly_d   = mem_ren_q;
        mem_ren_d   = 1'b0;
        mem_addr_d  = mem_addr_q;

        // Memory data arrives one clk after the strobe.
        if (ren_dly_q) begin
            prefetch_d = mem_rdata;
        end

        if (cs_n_s) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            byte_cnt_d  = 2'd0;
            load_pend_d = 1'b0;
            armed_d     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (armed_q) begin
                        state_d = ST_CMD;
                        armed_d = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        rx_sr_d   = rx_byte[6:0];
                        if (bit_cnt_q == 3'd7) begin
                            cmd_d      = rx_byte;
                            byte_cnt_d = 2'd0;
                            tx_sr_d    = 8'h00;
                            if (rx_byte == CMD_READ) begin
                                state_d = ST_ADDR;
                            end else if (rx_byte == CMD_JEDEC || rx_byte == CMD_RDSR) begin
                                state_d     = ST_DATA;
                                load_pend_d = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        addr_sr_d = addr_full[ADDR_W-2:0];
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd2) begin
                                state_d     = ST_DATA;
                                byte_cnt_d  = 2'd0;
                                load_pend_d = 1'b1;
                                mem_ren_d   = 1'b1;
                                mem_addr_d  = addr_full;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            load_pend_d = 1'b1;
                            if (cmd_q == CMD_READ) begin
                                mem_ren_d  = 1'b1;
                                mem_addr_d = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                    if (sck_fall) begin
                        if (load_pend_q) begin
                            tx_sr_d     = next_byte;
                            load_pend_d = 1'b0;
                            if (byte_cnt_q != 2'd3) begin
                                byte_cnt_d = byte_cnt_q + 2'd1;
                            end
                        end else begin
                            tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        miso_oe_d = (state_d == ST_DATA);
        miso_d    = (state_d == ST_DATA) ? tx_sr_d[7] : 1'b0;
    end

    // Register all FSM state and the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 2'd0;
            rx_sr_q     <= 7'd0;
            cmd_q       <= 8'h00;
            addr_sr_q   <= '0;
            tx_sr_q     <= 8'h00;
            prefetch_q  <= 8'h00;
            load_pend_q <= 1'b0;
            armed_q     <= 1'b0;
            ren_dly_q   <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_sr_q     <= rx_sr_d;
            cmd_q       <= cmd_d;
            addr_sr_q   <= addr_sr_d;
            tx_sr_q     <= tx_sr_d;
            prefetch_q  <= prefetch_d;
            load_pend_q <= load_pend_d;
            armed_q     <= armed_d;
            ren_dly_q   <= ren_dly_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            mem_ren_q   <= mem_ren_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign mem_ren     = mem_ren_q;
    assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: bit-banged SPI master, byte memory and a
// reference model of the expected response bytes and memory read addresses.
module tb_spi_flash_responder;

    localparam int          ADDR_W   = 17;
    localparam int          MEM_SIZE = 1 << ADDR_W;
    localparam int          HALF     = 8;
    localparam logic [23:0] JEDEC    = 24'hEF4018;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              spi_cs_n  = 1'b1;
    logic              spi_sck   = 1'b0;
    logic              spi_mosi  = 1'b0;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'h00;

    logic [7:0]        mem [0:MEM_SIZE-1];
    logic [ADDR_W-1:0] ren_q[$];
    logic [7:0]        rx_q[$];
    int                total  = 0;
    int                bad    = 0;
    int                oe_err = 0;

    always #5 clk = ~clk;

    spi_flash_responder #(.ADDR_W(ADDR_W), .JEDEC_ID(JEDEC)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_cs_n    (spi_cs_n),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mem_ren     (mem_ren),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata)
    );

    // Synchronous memory: data valid the cycle after the strobe.
    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

    // Record every cycle the read strobe is high.
    always @(negedge clk) if (mem_ren === 1'b1) ren_q.push_back(mem_addr);

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish (observed=timeout required=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] cmd, input logic [23:0] addr, input int k);
        int a;
        if (cmd == 8'h03) begin
            a = (int'(addr) + k) % MEM_SIZE;
            return mem[a];
        end
        if (cmd == 8'h9F && k < 3) return JEDEC[8*(2-k) +: 8];
        return 8'h00;
    endfunction

    // Shift nbits of tx MSB first; sample MISO just before each rising edge.
    task automatic send_bits(input logic [7:0] tx, input int nbits, input logic exp_oe, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], spi_miso};
            if (spi_miso_oe !== exp_oe || (spi_miso_oe !== 1'b1 && spi_miso !== 1'b0)) oe_err++;
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic run_txn(input string name, input logic [7:0] cmd, input logic [23:0] addr, input int nbytes);
        logic [7:0] b;
        logic       data_oe;
        int         n_ren;
        data_oe = (cmd == 8'h03 || cmd == 8'h9F || cmd == 8'h05);
        ren_q.delete();
        rx_q.delete();
        oe_err = 0;
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        send_bits(cmd, 8, 1'b0, b);
        if (cmd == 8'h03)
            for (int k = 0; k < 3; k++) send_bits(addr[8*(2-k) +: 8], 8, 1'b0, b);
        for (int k = 0; k < nbytes; k++) begin
            send_bits(8'($urandom), 8, data_oe, b);
            rx_q.push_back(b);
        end
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
        for (int k = 0; k < nbytes; k++)
            check($sformatf("%s byte%0d", name, k), 32'(rx_q[k]), 32'(exp_byte(cmd, addr, k)));
        check({name, " oe"}, oe_err, 0);
        n_ren = (cmd == 8'h03) ? nbytes + 1 : 0;
        check({name, " ren_count"}, ren_q.size(), n_ren);
        for (int k = 0; k < n_ren && k < ren_q.size(); k++)
            check($sformatf("%s ren_addr%0d", name, k), 32'(ren_q[k]), (int'(addr) + k) % MEM_SIZE);
    endtask

    initial begin
        logic [7:0]  b;
        logic [7:0]  cmds [4];
        logic [7:0]  c;
        logic [23:0] a;

        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
        mem[17'h00010] = 8'hA5;
        mem[17'h00011] = 8'h3C;
        mem[17'h1FFFF] = 8'h11;
        mem[17'h00000] = 8'h22;
        mem[17'h00004] = 8'h5A;

        // Reset values, during and after reset.
        repeat (4) @(negedge clk);
        check("rst miso", spi_miso, 0);
        check("rst oe", spi_miso_oe, 0);
        check("rst ren", mem_ren, 0);
        check("rst addr", mem_addr, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst oe", spi_miso_oe, 0);
        check("post_rst addr", mem_addr, 0);

        run_txn("read", 8'h03, 24'h000010, 2);
        run_txn("jedec", 8'h9F, 24'h0, 4);
        run_txn("rdsr", 8'h05, 24'h0, 2);
        run_txn("wrap", 8'h03, 24'h01FFFF, 2);
        run_txn("unknown", 8'hAB, 24'h0, 3);
        run_txn("after_unknown", 8'h03, 24'h000011, 1);

        // CS abort after 11 address bits.
        ren_q.delete();
        oe_err = 0;
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        send_bits(8'h03, 8, 1'b0, b);
        send_bits(8'h00, 8, 1'b0, b);
        send_bits(8'h00, 3, 1'b0, b);
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
        check("abort ren_count", ren_q.size(), 0);
        check("abort oe", oe_err, 0);
        run_txn("after_abort", 8'h03, 24'h000004, 1);

        // Reset in the middle of the second data byte, CS still low.
        ren_q.delete();
        oe_err = 0;
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        send_bits(8'h03, 8, 1'b0, b);
        send_bits(8'h00, 8, 1'b0, b);
        send_bits(8'h01, 8, 1'b0, b);
        send_bits(8'h23, 8, 1'b0, b);
        send_bits(8'($urandom), 8, 1'b1, b);
        check("mid_rst byte0", b, mem[17'h00123]);
        send_bits(8'($urandom), 4, 1'b1, b);
        check("mid_rst pre oe", oe_err, 0);
        rst = 1'b1;
        #1;
        check("mid_rst miso", spi_miso, 0);
        check("mid_rst oe", spi_miso_oe, 0);
        check("mid_rst ren", mem_ren, 0);
        check("mid_rst addr", mem_addr, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ren_q.delete();
        oe_err = 0;
        send_bits(8'h03, 8, 1'b0, b);
        send_bits(8'h00, 8, 1'b0, b);
        send_bits(8'h00, 8, 1'b0, b);
        send_bits(8'h10, 8, 1'b0, b);
        check("stale_cs oe", oe_err, 0);
        check("stale_cs ren_count", ren_q.size(), 0);
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
        run_txn("after_rst", 8'h03, 24'h000123, 2);

        // Random commands, addresses (including truncated high bits) and lengths.
        cmds[0] = 8'h03; cmds[1] = 8'h9F; cmds[2] = 8'h05; cmds[3] = 8'h03;
        for (int n = 0; n < 8; n++) begin
            c = cmds[$urandom_range(3, 0)];
            a = 24'($urandom);
            run_txn($sformatf("rand%0d", n), c, a, $urandom_range(4, 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
